// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF->ID pipeline register.
package pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Canonical NOP presented on the decode side when no entry is valid.
  localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Occupancy states; a single-entry build only ever uses EMPTY and ONE (FULL).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // Default-width view of the fetch-to-decode payload.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pcplus4;
  } if_id_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register with a load enable and a valid bit.
module pipe_skid_entry #(
  parameter int unsigned   W         = 96,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid,
  output logic [W-1:0] data
);

  // Hold until loaded; reset clears the valid bit and restores the idle payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= valid_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/if_id_pipe.sv
// Elastic IF->ID pipeline register with stall, flush and optional skid entry.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pcplus4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam int unsigned PW         = 3 * XLEN;
  localparam logic        PASS_READY = (DEPTH == 1);
  localparam logic        SKID       = (DEPTH == 2);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } payload_t;

  localparam logic [PW-1:0] NOP_PAYLOAD = {NOP_INSTR, {(2 * XLEN){1'b0}}};

  // Only a plain register or a two-entry skid buffer is meaningful.
  if (!(DEPTH == 1 || DEPTH == 2)) begin : g_bad_depth
    $error("if_id_pipe: DEPTH must be 1 or 2");
  end

  pipe_state_e state;
  logic        rdy_q;
  logic        accept;
  logic        consume;
  payload_t    in_p;
  payload_t    head_d;
  payload_t    head_q;
  logic        head_v;
  logic        head_ld;
  logic        head_dv;
  payload_t    skid_q;
  logic        skid_v;

  assign in_p    = '{instr: in_instr, pc: in_pc, pcplus4: in_pcplus4};
  assign in_ready = rdy_q | (PASS_READY & out_ready);
  assign accept  = in_valid & in_ready;
  assign consume = head_v & out_ready;

  assign out_valid   = head_v;
  assign out_instr   = head_q.instr;
  assign out_pc      = head_q.pc;
  assign out_pcplus4 = head_q.pcplus4;

  // Occupancy FSM; rdy_q holds "room without a consume" for next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else if (flush) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= ONE;
            rdy_q <= SKID;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state <= TWO;
            rdy_q <= 1'b0;
          end else if (!accept && consume) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
          end
        end
        TWO: begin
          if (consume) begin
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Head entry update: new data, promotion of the skid entry, or clear to NOP.
  always_comb begin
    head_ld = 1'b0;
    head_dv = 1'b0;
    head_d  = NOP_PAYLOAD;
    if (flush) begin
      head_ld = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_ld = 1'b1;
            head_dv = 1'b1;
            head_d  = in_p;
          end
        end
        ONE: begin
          if (consume) begin
            head_ld = 1'b1;
            if (accept) begin
              head_dv = 1'b1;
              head_d  = in_p;
            end
          end
        end
        TWO: begin
          if (consume) begin
            head_ld = 1'b1;
            head_dv = skid_v;
            head_d  = skid_q;
          end
        end
        default: begin
          head_ld = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_entry #(
    .W         (PW),
    .RESET_VAL (NOP_PAYLOAD)
  ) u_head (
    .clock   (clock),
    .reset   (reset),
    .load    (head_ld),
    .valid_d (head_dv),
    .data_d  (head_d),
    .valid   (head_v),
    .data    (head_q)
  );

  if (DEPTH == 2) begin : g_skid
    logic     skid_ld;
    logic     skid_dv;
    payload_t skid_d;

    // Skid captures input when the head is stalled, clears when promoted or flushed.
    always_comb begin
      skid_ld = 1'b0;
      skid_dv = 1'b0;
      skid_d  = NOP_PAYLOAD;
      if (flush) begin
        skid_ld = 1'b1;
      end else if (state == ONE && accept && !consume) begin
        skid_ld = 1'b1;
        skid_dv = 1'b1;
        skid_d  = in_p;
      end else if (state == TWO && consume) begin
        skid_ld = 1'b1;
      end
    end

    pipe_skid_entry #(
      .W         (PW),
      .RESET_VAL (NOP_PAYLOAD)
    ) u_skid (
      .clock   (clock),
      .reset   (reset),
      .load    (skid_ld),
      .valid_d (skid_dv),
      .data_d  (skid_d),
      .valid   (skid_v),
      .data    (skid_q)
    );
  end else begin : g_no_skid
    assign skid_v = 1'b0;
    assign skid_q = '0;
  end

`ifdef IF_ID_PERF_EN
  logic stall_ev;
  logic flush_ev;

  assign stall_ev = head_v & ~out_ready;
  assign flush_ev = flush & ((state != EMPTY) | in_valid);

  // Saturating stall and effective-flush counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: a DEPTH=2 and a DEPTH=1 instance share stimulus and
// are compared each cycle against a queue-style model of an elastic FIFO.
// Define IF_ID_PERF_EN to include the performance counter checks.
module tb_if_id_pipe;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pcplus4;

  logic        in_ready2, out_valid2, in_ready1, out_valid1;
  logic [31:0] out_instr2, out_pc2, out_pcplus42;
  logic [31:0] out_instr1, out_pc1, out_pcplus41;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt2, flush_cnt2, stall_cnt1, flush_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  if_id_pipe #(.XLEN(32), .DEPTH(2), .NOP_INSTR(32'h0000_0000)) dut2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .out_pcplus4(out_pcplus42)
`ifdef IF_ID_PERF_EN
    , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
  );

  if_id_pipe #(.XLEN(32), .DEPTH(1), .NOP_INSTR(32'h0000_0013)) dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_instr(out_instr1), .out_pc(out_pc1), .out_pcplus4(out_pcplus41)
`ifdef IF_ID_PERF_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Index 0 = DEPTH 2 instance, index 1 = DEPTH 1 instance.
  logic        ov  [2];
  logic        rdy [2];
  logic [31:0] oi  [2];
  logic [31:0] op  [2];
  logic [31:0] op4 [2];
  assign ov[0] = out_valid2;   assign ov[1] = out_valid1;
  assign rdy[0] = in_ready2;   assign rdy[1] = in_ready1;
  assign oi[0] = out_instr2;   assign oi[1] = out_instr1;
  assign op[0] = out_pc2;      assign op[1] = out_pc1;
  assign op4[0] = out_pcplus42; assign op4[1] = out_pcplus41;

  // Model: FIFO contents per instance, capacity and idle instruction.
  int          cnt [2] = '{0, 0};
  logic [95:0] ent [2][2];
  int          dep [2] = '{2, 1};
  logic [31:0] nop [2] = '{32'h0000_0000, 32'h0000_0013};
  logic [31:0] sc  [2] = '{32'd0, 32'd0};
  logic [31:0] fc  [2] = '{32'd0, 32'd0};

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (depth%0d inst): got %h expected %h", name, dep[d], act, exp);
    end
  endtask

  // Every cycle: compare outputs with the model, then advance it by the edge to come.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      logic        ev, er, acc, con;
      logic [95:0] hd;
      int          nc;
      ev = (cnt[d] > 0);
      hd = ev ? ent[d][0] : {nop[d], 64'h0};
      er = (cnt[d] < dep[d]) || (dep[d] == 1 && out_ready);
      check("out_valid", d, 32'(ov[d]), 32'(ev));
      check("out_instr", d, oi[d], hd[95:64]);
      check("out_pc", d, op[d], hd[63:32]);
      check("out_pcplus4", d, op4[d], hd[31:0]);
      check("in_ready", d, 32'(rdy[d]), 32'(er));
`ifdef IF_ID_PERF_EN
      check("stall_cnt", d, (d == 0) ? stall_cnt2 : stall_cnt1, sc[d]);
      check("flush_cnt", d, (d == 0) ? flush_cnt2 : flush_cnt1, fc[d]);
`endif
      acc = in_valid && er;
      con = ev && out_ready;
      if (reset) begin
        cnt[d] = 0;
        sc[d] = 32'd0;
        fc[d] = 32'd0;
      end else begin
        if (ev && !out_ready && sc[d] != 32'hFFFF_FFFF) sc[d] = sc[d] + 32'd1;
        if (flush && (ev || in_valid) && fc[d] != 32'hFFFF_FFFF) fc[d] = fc[d] + 32'd1;
        if (flush) begin
          cnt[d] = 0;
        end else begin
          nc = cnt[d];
          if (con) begin
            ent[d][0] = ent[d][1];
            nc--;
          end
          if (acc) begin
            ent[d][nc] = {in_instr, in_pc, in_pcplus4};
            nc++;
          end
          cnt[d] = nc;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
    in_instr   = $urandom;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_pcplus4 = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst out_valid", 0, 32'(out_valid2), 32'd0);
    check("rst out_instr", 0, out_instr2, 32'd0);
    check("rst in_ready", 0, 32'(in_ready2), 32'd1);
    check("rst out_pc", 0, out_pc2, 32'd0);
    check("rst out_pcplus4", 0, out_pcplus42, 32'd0);
    check("rst nop instr", 1, out_instr1, 32'h0000_0013);
    cyc();

    // Streaming with out_ready=1
    drive(32'h0); cyc();
    drive(32'h4);
    @(negedge clock);
    check("stream v0", 0, 32'(out_valid2), 32'd1);
    check("stream pc0", 0, out_pc2, 32'h0);
    check("stream p4_0", 0, out_pcplus42, 32'h4);
    cyc(); drive(32'h8);
    @(negedge clock);
    check("stream pc1", 0, out_pc2, 32'h4);
    check("stream p4_1", 0, out_pcplus42, 32'h8);
    cyc(); in_valid = 1'b0;
    @(negedge clock);
    check("stream pc2", 0, out_pc2, 32'h8);
    check("stream p4_2", 0, out_pcplus42, 32'hC);
    cyc();
    @(negedge clock);
    check("stream drained", 0, 32'(out_valid2), 32'd0);

    // Stall into TWO, then release
    cyc(); drive(32'h100); out_ready = 1'b0;
    cyc(); drive(32'h104);
    cyc(); drive(32'h108);
    @(negedge clock);
    check("stall in_ready", 0, 32'(in_ready2), 32'd0);
    check("stall out_pc", 0, out_pc2, 32'h100);
    cyc(); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("release pc0", 0, out_pc2, 32'h100);
    cyc();
    @(negedge clock);
    check("release pc1", 0, out_pc2, 32'h104);
    cyc();
    @(negedge clock);
    check("release empty", 0, 32'(out_valid2), 32'd0);

    // Flush while TWO with a same-cycle input
    cyc(); drive(32'h100); out_ready = 1'b0;
    cyc(); drive(32'h104);
    cyc(); drive(32'h108); flush = 1'b1;
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush out_valid", 0, 32'(out_valid2), 32'd0);
    check("flush out_instr", 0, out_instr2, 32'd0);
    check("flush in_ready", 0, 32'(in_ready2), 32'd1);
    cyc(); out_ready = 1'b1;
    @(negedge clock);
    check("flush no 0x108", 0, 32'(out_valid2), 32'd0);

    // DEPTH=1 with out_ready 1,0,1 and continuous input
    cyc(); drive(32'h300);
    cyc(); drive(32'h304); out_ready = 1'b0;
    @(negedge clock);
    check("d1 ready low", 1, 32'(in_ready1), 32'd0);
    check("d1 hold pc", 1, out_pc1, 32'h300);
    cyc(); out_ready = 1'b1;
    @(negedge clock);
    check("d1 ready high", 1, 32'(in_ready1), 32'd1);
    cyc(); drive(32'h308);
    @(negedge clock);
    check("d1 next pc", 1, out_pc1, 32'h304);
    cyc(); in_valid = 1'b0;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_pc      = $urandom & 32'hFFFF_FFFC;
      in_pcplus4 = in_pc + 32'd4;
      in_instr   = $urandom;
      out_ready  = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; reset = 1'b0;

`ifdef IF_ID_PERF_EN
    // Three stalled cycles and one effective flush
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    @(negedge clock);
    check("perf rst stall", 0, stall_cnt2, 32'd0);
    check("perf rst flush", 0, flush_cnt2, 32'd0);
    cyc(); drive(32'h200); out_ready = 1'b0;
    cyc(); in_valid = 1'b0;
    cyc(); cyc(); cyc();
    out_ready = 1'b1; flush = 1'b1;
    cyc(); flush = 1'b0;
    @(negedge clock);
    check("perf stall3", 0, stall_cnt2, 32'd3);
    check("perf flush1", 0, flush_cnt2, 32'd1);
    check("perf stall3", 1, stall_cnt1, 32'd3);
    check("perf flush1", 1, flush_cnt1, 32'd1);
    cyc(); reset = 1'b1; cyc(); reset = 1'b0;
    @(negedge clock);
    check("perf clr stall", 0, stall_cnt2, 32'd0);
    check("perf clr flush", 0, flush_cnt2, 32'd0);
`endif

    cyc();
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
